// File: rtl/sweep_scan.sv
// Two-axis servo sweep: steps H then V pulse widths, samples an ADC at each point,
// flags new maxima to an external storage register and parks each axis at its best position.
module sweep_scan #(
  parameter int unsigned PW_MIN  = 100000,
  parameter int unsigned PW_MAX  = 200000,
  parameter int unsigned PW_STEP = 1000,
  parameter int unsigned SETTLE  = 2000000,
  parameter int unsigned ADC_TO  = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [11:0] ADC_DATA,
  input  logic        ADC_VALID,
  input  logic [11:0] LV,
  input  logic [31:0] pulseWidth_max_H,
  input  logic [31:0] pulseWidth_max_V,
  output logic        ADC_REQ,
  output logic        GT,
  output logic [11:0] PV,
  output logic [31:0] pulseWidth_H,
  output logic [31:0] pulseWidth_V,
  output logic        SCAN_CLR,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, MOVE, WAIT_ADC, CMP, PARK_H, MOVE_V_START, PARK_V, FIN
  } state_t;

  localparam logic [31:0] PW_MIN_W  = 32'(PW_MIN);
  localparam logic [31:0] PW_MAX_W  = 32'(PW_MAX);
  localparam logic [31:0] PW_STEP_W = 32'(PW_STEP);
  localparam logic [31:0] SETTLE_W  = 32'(SETTLE);
  localparam logic [31:0] ADC_TO_W  = 32'(ADC_TO);

  state_t      state_q, state_d;
  logic        axis_q, axis_d;
  logic        step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic [11:0] sample_q, sample_d;
  logic [31:0] pw_h_q, pw_h_d;
  logic [31:0] pw_v_q, pw_v_d;
  logic [11:0] pv_q, pv_d;
  logic        gt_q, gt_d;
  logic        adc_req_q, adc_req_d;
  logic        scan_clr_q, scan_clr_d;
  logic        done_q, done_d;

  logic [31:0] active_pw;
  logic [32:0] stepped_sum;
  logic [31:0] next_pw;
  logic        at_end;
  logic        do_adv;

  // The step lands in the first MOVE cycle, so the width stays at the sampled
  // point while GT is high and the storage register captures the right position.
  always_comb begin
    state_d    = state_q;
    axis_d     = axis_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    pw_h_d     = pw_h_q;
    pw_v_d     = pw_v_q;
    pv_d       = pv_q;
    gt_d       = 1'b0;
    adc_req_d  = 1'b0;
    scan_clr_d = 1'b0;
    done_d     = 1'b0;
    do_adv     = 1'b0;

    active_pw   = axis_q ? pw_v_q : pw_h_q;
    at_end      = (active_pw >= PW_MAX_W);
    stepped_sum = {1'b0, active_pw} + {1'b0, PW_STEP_W};
    next_pw     = (stepped_sum < {1'b0, PW_MAX_W}) ? stepped_sum[31:0] : PW_MAX_W;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = CLEAR;
          scan_clr_d = 1'b1;
        end
      end
      CLEAR: begin
        pw_h_d  = PW_MIN_W;
        pw_v_d  = PW_MIN_W;
        axis_d  = 1'b0;
        step_d  = 1'b0;
        cnt_d   = '0;
        state_d = MOVE;
      end
      MOVE: begin
        if (step_q) begin
          step_d = 1'b0;
          if (axis_q) pw_v_d = next_pw;
          else        pw_h_d = next_pw;
        end
        if (cnt_q >= SETTLE_W - 32'd1) begin
          cnt_d     = '0;
          adc_req_d = 1'b1;
          state_d   = WAIT_ADC;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_ADC: begin
        if (ADC_VALID) begin
          sample_d = ADC_DATA;
          cnt_d    = '0;
          state_d  = CMP;
        end else if (cnt_q >= ADC_TO_W - 32'd1) begin
          cnt_d  = '0;
          do_adv = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CMP: begin
        if (sample_q > LV) begin
          gt_d = 1'b1;
          pv_d = sample_q;
        end
        do_adv = 1'b1;
      end
      // Park states spend one cycle letting the storage register absorb a
      // trailing GT before its best position is read back.
      PARK_H: begin
        if (cnt_q == 32'd0) begin
          cnt_d = 32'd1;
        end else begin
          pw_h_d  = pulseWidth_max_H;
          axis_d  = 1'b1;
          cnt_d   = '0;
          state_d = MOVE_V_START;
        end
      end
      MOVE_V_START: begin
        pw_v_d  = PW_MIN_W;
        cnt_d   = '0;
        state_d = MOVE;
      end
      PARK_V: begin
        if (cnt_q == 32'd0) begin
          cnt_d = 32'd1;
        end else begin
          pw_v_d  = pulseWidth_max_V;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_adv) begin
      if (at_end) begin
        state_d = axis_q ? PARK_V : PARK_H;
      end else begin
        step_d  = 1'b1;
        state_d = MOVE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      axis_q     <= 1'b0;
      step_q     <= 1'b0;
      cnt_q      <= '0;
      sample_q   <= '0;
      pw_h_q     <= PW_MIN_W;
      pw_v_q     <= PW_MIN_W;
      pv_q       <= '0;
      gt_q       <= 1'b0;
      adc_req_q  <= 1'b0;
      scan_clr_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      axis_q     <= axis_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      pw_h_q     <= pw_h_d;
      pw_v_q     <= pw_v_d;
      pv_q       <= pv_d;
      gt_q       <= gt_d;
      adc_req_q  <= adc_req_d;
      scan_clr_q <= scan_clr_d;
      done_q     <= done_d;
    end
  end

  assign ADC_REQ      = adc_req_q;
  assign GT           = gt_q;
  assign PV           = pv_q;
  assign pulseWidth_H = pw_h_q;
  assign pulseWidth_V = pw_v_q;
  assign SCAN_CLR     = scan_clr_q;
  assign DONE         = done_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_sweep_scan.sv
// Bench for sweep_scan: table-driven and random scans against an abstract sweep model,
// plus reset-abort and clamped-step sequences.
module tb_sweep_scan;
  localparam int PW_MIN = 10;
  localparam int PW_MAX = 30;
  localparam int PW_STEP = 10;
  localparam int SETTLE = 4;
  localparam int ADC_TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [11:0] ADC_DATA = '0;
  logic        ADC_VALID = 1'b0;
  logic [11:0] lv = '0;
  logic [31:0] mh = '0, mv = '0;
  logic        ADC_REQ, GT, SCAN_CLR, BUSY, DONE;
  logic [11:0] PV;
  logic [31:0] pulseWidth_H, pulseWidth_V;

  logic        start15 = 1'b0, valid15 = 1'b0;
  logic        req15, gt15, clr15, busy15, done15;
  logic [11:0] pv15;
  logic [31:0] pwh15, pwv15;
  logic [11:0] zero12 = '0;
  logic [31:0] zero32 = '0;

  int errors = 0, checks = 0;
  int req_cnt = 0, clr_cnt = 0, done_cnt = 0, gt_cnt = 0, cur_idx = 0;
  logic [5:0]  gt_mask = '0;
  logic [11:0] cur_sample = '0;
  logic gt_p = 0, req_p = 0, clr_p = 0, done_p = 0;
  int w15_h[$], w15_v[$];
  int gt15_cnt = 0;

  always #5 CLK = ~CLK;

  sweep_scan #(.PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_STEP(PW_STEP), .SETTLE(SETTLE), .ADC_TO(ADC_TO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
    .LV(lv), .pulseWidth_max_H(mh), .pulseWidth_max_V(mv),
    .ADC_REQ(ADC_REQ), .GT(GT), .PV(PV), .pulseWidth_H(pulseWidth_H), .pulseWidth_V(pulseWidth_V),
    .SCAN_CLR(SCAN_CLR), .BUSY(BUSY), .DONE(DONE));

  sweep_scan #(.PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .PW_STEP(15), .SETTLE(SETTLE), .ADC_TO(ADC_TO)) dut15 (
    .CLK(CLK), .RST(RST), .START(start15), .ADC_DATA(zero12), .ADC_VALID(valid15),
    .LV(zero12), .pulseWidth_max_H(zero32), .pulseWidth_max_V(zero32),
    .ADC_REQ(req15), .GT(gt15), .PV(pv15), .pulseWidth_H(pwh15), .pulseWidth_V(pwv15),
    .SCAN_CLR(clr15), .BUSY(busy15), .DONE(done15));

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // External storage register: cleared by SCAN_CLR, loaded on GT.
  always @(posedge CLK) begin
    if (SCAN_CLR) begin
      lv <= '0; mh <= '0; mv <= '0;
    end else if (GT) begin
      lv <= PV; mh <= pulseWidth_H; mv <= pulseWidth_V;
    end
  end

  always @(posedge CLK) valid15 <= req15;

  always @(negedge CLK) begin
    if (ADC_REQ) req_cnt++;
    if (SCAN_CLR) clr_cnt++;
    if (DONE) done_cnt++;
    if (GT) begin
      gt_cnt++;
      gt_mask[cur_idx] = 1'b1;
      chk("pv_at_gt", PV, cur_sample);
    end
    if (GT) chk("gt_back_to_back", gt_p, 0);
    if (ADC_REQ) chk("req_back_to_back", req_p, 0);
    if (SCAN_CLR) chk("clr_back_to_back", clr_p, 0);
    if (DONE) chk("done_back_to_back", done_p, 0);
    gt_p = GT; req_p = ADC_REQ; clr_p = SCAN_CLR; done_p = DONE;
    if (req15) begin
      w15_h.push_back(int'(pwh15));
      w15_v.push_back(int'(pwv15));
    end
    if (gt15) gt15_cnt++;
  end

  // k-th sweep point of an axis: PW_MIN + k*step, clamped to PW_MAX.
  function automatic int w_at(int k, int step);
    int w = PW_MIN + k * step;
    return (w > PW_MAX) ? PW_MAX : w;
  endfunction

  function automatic logic [5:0][12:0] mk(int a, int b, int c, int d, int e, int f);
    int t[6];
    logic [5:0][12:0] r;
    t = '{a, b, c, d, e, f};
    for (int i = 0; i < 6; i++) r[i] = (t[i] < 0) ? 13'h1000 : 13'(t[i]);
    return r;
  endfunction

  // Abstract model: running maximum over all samples; the best position of each
  // axis is where that axis last raised the maximum (storage starts at 0).
  task automatic model(input logic [5:0][12:0] s, output logic [5:0] m, output int ph, output int pv);
    int best = 0;
    m = '0; ph = 0; pv = 0;
    for (int i = 0; i < 6; i++) begin
      if (!s[i][12] && int'(s[i][11:0]) > best) begin
        best = int'(s[i][11:0]);
        m[i] = 1'b1;
        if (i < 3) begin ph = w_at(i, PW_STEP); pv = PW_MIN; end
        else pv = w_at(i - 3, PW_STEP);
      end
    end
  endtask

  task automatic run_scan(input logic [5:0][12:0] s, input bit mid, input logic [5:0] emask,
                          input int eph, input int epv, input int tag);
    int k;
    gt_mask = '0; req_cnt = 0; clr_cnt = 0; done_cnt = 0; cur_idx = 0;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    if (mid) begin
      repeat (2) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK); START = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      k = 0;
      while (!ADC_REQ && k < 60) begin @(negedge CLK); k++; end
      if (!ADC_REQ) begin chk("adc_req_timeout", 0, 1); return; end
      cur_idx = i;
      if (i < 3) begin
        chk("req_width_h", pulseWidth_H, w_at(i, PW_STEP));
        chk("req_width_v_held", pulseWidth_V, PW_MIN);
      end else begin
        chk("req_width_v", pulseWidth_V, w_at(i - 3, PW_STEP));
        chk("req_width_h_parked", pulseWidth_H, eph);
      end
      if (!s[i][12]) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        cur_sample = s[i][11:0];
        ADC_DATA = s[i][11:0]; ADC_VALID = 1'b1;
        @(negedge CLK); ADC_VALID = 1'b0;
      end
    end
    k = 0;
    while (!DONE && k < 80) begin @(negedge CLK); k++; end
    chk("done_seen", DONE, 1);
    chk("park_h", pulseWidth_H, eph);
    chk("park_v", pulseWidth_V, epv);
    chk("busy_in_fin", BUSY, 1);
    @(negedge CLK);
    chk("busy_after", BUSY, 0);
    repeat (5) @(negedge CLK);
    chk("gt_mask", gt_mask, emask);
    chk("scan_clr_count", clr_cnt, 1);
    chk("done_count", done_cnt, 1);
    chk("adc_req_count", req_cnt, 6);
    $display("scan %0d: gt_mask=%b park_h=%0d park_v=%0d", tag, gt_mask, pulseWidth_H, pulseWidth_V);
  endtask

  typedef struct {
    logic [5:0][12:0] s;
    bit               mid;
    logic [5:0]       mask;
    int               ph;
    int               pv;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [5:0][12:0] rs;
    logic [5:0] rm;
    int rph, rpv, k, snap;

    tbl[0] = '{mk(100, 300, 200, 50, 400, 400), 1'b0, 6'b010011, 20, 20};
    tbl[1] = '{mk(0, 0, 0, 0, 0, 0),            1'b0, 6'b000000, 0, 0};
    tbl[2] = '{mk(100, -1, 50, 10, 20, 500),    1'b1, 6'b100001, 10, 30};
    tbl[3] = '{mk(1, 2, 3, 4, 5, 6),            1'b0, 6'b111111, 30, 30};
    tbl[4] = '{mk(500, -1, -1, -1, -1, -1),     1'b0, 6'b000001, 10, 10};

    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_pv", PV, 0);
    chk("rst_pw_h", pulseWidth_H, PW_MIN);
    chk("rst_pw_v", pulseWidth_V, PW_MIN);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_adc_req", ADC_REQ, 0);

    for (int t = 0; t < 5; t++)
      run_scan(tbl[t].s, tbl[t].mid, tbl[t].mask, tbl[t].ph, tbl[t].pv, t);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 6; i++) begin
        k = int'($urandom_range(0, 9));
        if (k == 0) rs[i] = 13'h1000;
        else if (k < 4) rs[i] = 13'($urandom_range(0, 15));
        else rs[i] = 13'($urandom_range(0, 4095));
      end
      model(rs, rm, rph, rpv);
      run_scan(rs, t[0], rm, rph, rpv, 100 + t);
    end

    // Reset while waiting on the ADC: immediate return to reset values, late data ignored.
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    k = 0;
    while (!ADC_REQ && k < 60) begin @(negedge CLK); k++; end
    chk("abort_req_seen", ADC_REQ, 1);
    #2 RST = 1'b1;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_adc_req", ADC_REQ, 0);
    chk("abort_pv", PV, 0);
    chk("abort_gt", GT, 0);
    chk("abort_done", DONE, 0);
    chk("abort_clr", SCAN_CLR, 0);
    chk("abort_pw_h", pulseWidth_H, PW_MIN);
    chk("abort_pw_v", pulseWidth_V, PW_MIN);
    @(negedge CLK); RST = 1'b0;
    snap = gt_cnt; req_cnt = 0; done_cnt = 0;
    ADC_DATA = 12'd4000; ADC_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    ADC_VALID = 1'b0;
    repeat (20) @(negedge CLK);
    chk("abort_no_gt", gt_cnt - snap, 0);
    chk("abort_no_req", req_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", BUSY, 0);
    $display("abort: reset in WAIT_ADC handled");

    run_scan(tbl[0].s, 1'b0, tbl[0].mask, tbl[0].ph, tbl[0].pv, 200);

    // Step 15 over 10..30 clamps the last point to 30.
    @(negedge CLK); start15 = 1'b1;
    @(negedge CLK); start15 = 1'b0;
    k = 0;
    while (!done15 && k < 300) begin @(negedge CLK); k++; end
    chk("s15_done", done15, 1);
    chk("s15_req_count", w15_h.size(), 6);
    if (w15_h.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        chk("s15_width_h", w15_h[i], w_at(i, 15));
        chk("s15_width_v", w15_v[i + 3], w_at(i, 15));
      end
    end
    chk("s15_no_gt", gt15_cnt, 0);
    $display("step15: widths h=%p v=%p", w15_h, w15_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sweep_scan.md
SWEEP_SCAN -- requirements
Module: sweep_scan

Interface
REQ-001 SHALL have parameter PW_MIN, default 100000, minimum servo pulse width in CLK cycles.
REQ-002 SHALL have parameter PW_MAX, default 200000, maximum servo pulse width in CLK cycles (PW_MAX > PW_MIN).
REQ-003 SHALL have parameter PW_STEP, default 1000, sweep increment in CLK cycles (nonzero).
REQ-004 SHALL have parameter SETTLE, default 2000000, servo settle wait in CLK cycles after each position change (>= 1).
REQ-005 SHALL have parameter ADC_TO, default 1024, cycles to wait for ADC_VALID before abandoning a sample.
REQ-006 SHALL have ports: one clock; reset is asynchronous and active-high, named CLK and RST.
REQ-007 SHALL have: CLK in 1 system clock; RST in 1 async active-high reset.
REQ-008 SHALL have: START in 1 single-cycle request to begin a scan.
REQ-009 SHALL have: ADC_DATA in 12 conversion result; ADC_VALID in 1 result strobe.
REQ-010 SHALL have: LV in 12 stored maximum from the storage register; pulseWidth_max_H, pulseWidth_max_V in 32 each, stored best positions.
REQ-011 SHALL have: ADC_REQ out 1 conversion request pulse; GT out 1 new-maximum strobe; PV out 12 candidate value.
REQ-012 SHALL have: pulseWidth_H, pulseWidth_V out 32 each, commanded servo pulse widths.
REQ-013 SHALL have: SCAN_CLR out 1 storage-clear pulse; BUSY out 1; DONE out 1.

Function
REQ-014 SHALL implement states IDLE, CLEAR, MOVE, WAIT_ADC, CMP, PARK_H, MOVE_V_START, PARK_V, FIN; one axis flag selects H or V in MOVE/WAIT_ADC/CMP.
REQ-015 IDLE: START=1 -> CLEAR; START while not IDLE SHALL be ignored.
REQ-016 CLEAR: SCAN_CLR=1 for exactly one cycle; pulseWidth_H=PW_MIN, pulseWidth_V=PW_MIN, axis=H; -> MOVE.
REQ-017 MOVE: count SETTLE cycles from entry, then ADC_REQ=1 for one cycle, -> WAIT_ADC.
REQ-018 WAIT_ADC: first ADC_VALID=1 -> CMP with ADC_DATA registered; ADC_VALID outside WAIT_ADC SHALL be ignored.
REQ-019 WAIT_ADC: ADC_TO cycles with no ADC_VALID -> step (REQ-021) without GT.
REQ-020 CMP: registered sample > LV (unsigned, strict) -> GT=1 for one cycle, PV=sample same cycle; equal or less -> GT=0, PV unchanged.
REQ-021 Step: if active pulse width + PW_STEP < PW_MAX, add PW_STEP; else if width < PW_MAX, set PW_MAX (clamp, final point always sampled); else axis end -> MOVE on step, axis end as REQ-022.
REQ-022 H axis end -> PARK_H: pulseWidth_H = pulseWidth_max_H (sampled one cycle after last CMP), axis=V, -> MOVE (V sweep from PW_MIN, H held).
REQ-023 V axis end -> PARK_V: pulseWidth_V = pulseWidth_max_V, -> FIN.
REQ-024 FIN: DONE=1 for one cycle, -> IDLE; pulse widths hold until next CLEAR.
REQ-025 BUSY SHALL be 1 in every state except IDLE.
REQ-026 GT, ADC_REQ, SCAN_CLR, DONE SHALL be registered single-cycle pulses, never two consecutive cycles.
REQ-027 Pulse-width arithmetic SHALL be 32-bit unsigned with no wrap (clamp per REQ-021).
REQ-028 Only one GT per sample; samples per axis = ceil((PW_MAX-PW_MIN)/PW_STEP)+1.

Reset
REQ-029 RST=1 SHALL asynchronously force IDLE, GT=0, PV=0, ADC_REQ=0, SCAN_CLR=0, BUSY=0, DONE=0, pulseWidth_H=PW_MIN, pulseWidth_V=PW_MIN, all counters 0.
REQ-030 RST mid-scan SHALL abort with no further pulses; next START begins a full scan.

Verification (PW_MIN=10, PW_MAX=30, PW_STEP=10, SETTLE=4, ADC_TO=8, storage model captures on GT)
REQ-031 START, ADC returns H samples 100,300,200, V samples 50,400,400 -> GT on H samples 1,2 and V sample 2 only; pulseWidth_H parks 20, pulseWidth_V parks 20; DONE one pulse.
REQ-032 PW_STEP=15 -> H widths 10,25,30 (clamped); three ADC_REQ per axis.
REQ-033 No ADC_VALID on second request -> after 8 cycles width advances, no GT, scan completes.
REQ-034 START asserted during MOVE -> ignored; SCAN_CLR count per scan stays 1.
REQ-035 RST asserted in WAIT_ADC -> outputs at REQ-029 values immediately; later ADC_VALID produces no GT.
REQ-036 Sample equal to LV (e.g. 0 after clear) -> no GT.
